// File: rtl/poly_operand_feeder.sv
// Serialises one A/B/C/X operand set onto data_out with press/release go strobes, then captures result_in.
// Latency 4*(1+GO_HIGH_CYCLES+GO_LOW_CYCLES)+RESULT_WAIT+1 cycles; start is accepted only while ready, abort cancels.
module poly_operand_feeder #(
   parameter int DATA_W         = 8,
   parameter int GO_HIGH_CYCLES = 2,
   parameter int GO_LOW_CYCLES  = 2,
   parameter int RESULT_WAIT    = 4
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              start,
   input  logic [DATA_W-1:0] a_in,
   input  logic [DATA_W-1:0] b_in,
   input  logic [DATA_W-1:0] c_in,
   input  logic [DATA_W-1:0] x_in,
   input  logic              abort,
   input  logic [DATA_W-1:0] result_in,
   output logic [DATA_W-1:0] data_out,
   output logic              go,
   output logic              ready,
   output logic              busy,
   output logic [DATA_W-1:0] result,
   output logic              done
);

   localparam int MAX_HL = (GO_HIGH_CYCLES > GO_LOW_CYCLES) ? GO_HIGH_CYCLES : GO_LOW_CYCLES;
   localparam int MAX_P  = (MAX_HL > RESULT_WAIT) ? MAX_HL : RESULT_WAIT;
   localparam int CW     = $clog2(MAX_P) + 1;

   typedef enum logic [2:0] {
      S_IDLE, S_SETUP, S_HI, S_LO, S_WAIT, S_CAPTURE
   } state_t;

   state_t            state;
   logic [CW-1:0]     cnt;
   logic [1:0]        idx;
   logic [DATA_W-1:0] ops [4];

   assign ready = (state == S_IDLE);
   assign busy  = (state != S_IDLE);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state    <= S_IDLE;
         cnt      <= '0;
         idx      <= '0;
         go       <= 1'b0;
         data_out <= '0;
         result   <= '0;
         done     <= 1'b0;
         for (int i = 0; i < 4; i++) ops[i] <= '0;
      end else begin
         done <= 1'b0;
         if (state != S_IDLE && abort) begin
            state    <= S_IDLE;
            go       <= 1'b0;
            data_out <= '0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (start && !abort) begin
                     ops[0]   <= a_in;
                     ops[1]   <= b_in;
                     ops[2]   <= c_in;
                     ops[3]   <= x_in;
                     idx      <= '0;
                     data_out <= a_in;
                     cnt      <= '0;
                     state    <= S_SETUP;
                  end
               end
               S_SETUP: begin
                  go    <= 1'b1;
                  cnt   <= CW'(GO_HIGH_CYCLES - 1);
                  state <= S_HI;
               end
               S_HI: begin
                  if (cnt == '0) begin
                     go    <= 1'b0;
                     cnt   <= CW'(GO_LOW_CYCLES - 1);
                     state <= S_LO;
                  end else begin
                     cnt <= cnt - 1'b1;
                  end
               end
               S_LO: begin
                  if (cnt != '0) begin
                     cnt <= cnt - 1'b1;
                  end else if (idx == 2'd3) begin
                     cnt   <= CW'(RESULT_WAIT - 1);
                     state <= S_WAIT;
                  end else begin
                     // data_out only moves here, so it is stable across every go edge
                     idx      <= idx + 2'd1;
                     data_out <= ops[idx + 2'd1];
                     cnt      <= '0;
                     state    <= S_SETUP;
                  end
               end
               S_WAIT: begin
                  if (cnt == '0) begin
                     result <= result_in;
                     done   <= 1'b1;
                     cnt    <= '0;
                     state  <= S_CAPTURE;
                  end else begin
                     cnt <= cnt - 1'b1;
                  end
               end
               S_CAPTURE: begin
                  state <= S_IDLE;
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_poly_operand_feeder.sv
// Directed bench: receiver stub computes A*A+C from the press sequence; a second instance covers 1/3/1 timing.
module tb_poly_operand_feeder;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic [7:0] a_in = '0, b_in = '0, c_in = '0, x_in = '0;
   logic [7:0] result_in;
   logic [7:0] data_out, result, data_out2, result2;
   logic       go, ready, busy, done, go2, ready2, busy2, done2;

   always #5 clk = ~clk;

   poly_operand_feeder dut (
      .clk(clk), .resetn(resetn), .start(start),
      .a_in(a_in), .b_in(b_in), .c_in(c_in), .x_in(x_in),
      .abort(abort), .result_in(result_in),
      .data_out(data_out), .go(go), .ready(ready), .busy(busy),
      .result(result), .done(done)
   );

   poly_operand_feeder #(.DATA_W(8), .GO_HIGH_CYCLES(1), .GO_LOW_CYCLES(3), .RESULT_WAIT(1)) dut2 (
      .clk(clk), .resetn(resetn), .start(start),
      .a_in(a_in), .b_in(b_in), .c_in(c_in), .x_in(x_in),
      .abort(abort), .result_in(8'hA5),
      .data_out(data_out2), .go(go2), .ready(ready2), .busy(busy2),
      .result(result2), .done(done2)
   );

   // receiver stub: latch data_out on each go rise, result = A*A + C (8-bit)
   logic       rx_clr = 1'b0;
   logic       go_q;
   logic [1:0] rx_k;
   logic [7:0] slot [4];
   always @(posedge clk) begin
      go_q <= go;
      if (rx_clr) rx_k <= '0;
      else if (go && !go_q) begin
         slot[rx_k] <= data_out;
         rx_k       <= rx_k + 2'd1;
      end
   end
   assign result_in = 8'(slot[0] * slot[0] + slot[2]);

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   logic [31:0] go_v, done_v, rdy_v, go2_v, done2_v;
   logic [7:0]  dout_l [32];
   logic [7:0]  res_l  [32];
   logic [7:0]  res2_l [32];

   task automatic launch(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] x);
      @(negedge clk);
      a_in = a; b_in = b; c_in = c; x_in = x;
      start  = 1'b1;
      rx_clr = 1'b1;
      @(posedge clk);
   endtask

   // cycle c = interval after the c-th edge following the start-sampling edge 0
   task automatic run(input int n, input int lock_c, input int abort_c);
      go_v = '0; done_v = '0; rdy_v = '0; go2_v = '0; done2_v = '0;
      for (int c = 1; c <= n; c++) begin
         @(negedge clk);
         go_v[c] = go; done_v[c] = done; rdy_v[c] = ready;
         go2_v[c] = go2; done2_v[c] = done2;
         dout_l[c] = data_out; res_l[c] = result; res2_l[c] = result2;
         rx_clr = 1'b0;
         start  = (c == lock_c);
         if (c == lock_c) a_in = 8'd9;
         abort  = (c == abort_c);
      end
      start = 1'b0;
      abort = 1'b0;
   endtask

   task automatic nominal_checks(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                                 input logic [7:0] x, input logic [7:0] res);
      logic [7:0] ops [4];
      ops[0] = a; ops[1] = b; ops[2] = c; ops[3] = x;
      check("go_vec",   go_v,   32'h0006_318C);
      check("done_vec", done_v, 32'h0200_0000);
      check("rdy_vec",  rdy_v,  32'h7C00_0000);
      for (int cy = 1; cy <= 25; cy++) begin
         int k;
         k = (cy - 1) / 5;
         if (k > 3) k = 3;
         check("data_out", {24'd0, dout_l[cy]}, {24'd0, ops[k]});
      end
      check("result", {24'd0, res_l[25]}, {24'd0, res});
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("rst_go",    {31'd0, go},    32'd0);
      check("rst_dout",  {24'd0, data_out}, 32'd0);
      check("rst_res",   {24'd0, result},   32'd0);
      check("rst_done",  {31'd0, done},  32'd0);
      check("rst_ready", {31'd0, ready}, 32'd1);
      check("rst_busy",  {31'd0, busy},  32'd0);
      resetn = 1'b1;

      // nominal, plus swept-parameter instance
      launch(8'd3, 8'd5, 8'd7, 8'd2);
      run(30, 0, 0);
      nominal_checks(8'd3, 8'd5, 8'd7, 8'd2, 8'd16);
      check("sweep_go",   go2_v,   32'h0002_1084);
      check("sweep_done", done2_v, 32'h0040_0000);
      check("sweep_res",  {24'd0, res2_l[22]}, 32'hA5);

      // 400 + 10 wraps to 154
      launch(8'd20, 8'd0, 8'd10, 8'd0);
      run(30, 0, 0);
      nominal_checks(8'd20, 8'd0, 8'd10, 8'd0, 8'd154);

      // second start while busy is ignored
      launch(8'd3, 8'd5, 8'd7, 8'd2);
      run(30, 5, 0);
      nominal_checks(8'd3, 8'd5, 8'd7, 8'd2, 8'd16);

      // abort during B's press
      launch(8'd4, 8'd5, 8'd6, 8'd7);
      run(12, 0, 7);
      check("abort_go",   go_v,   32'h0000_008C);
      check("abort_done", done_v, 32'h0);
      check("abort_rdy",  rdy_v,  32'h0000_1F00);
      check("abort_dout", {24'd0, dout_l[8]}, 32'd0);
      check("abort_res",  {24'd0, res_l[12]}, 32'd16);

      // async reset in the middle of C's press
      launch(8'd3, 8'd5, 8'd7, 8'd2);
      run(12, 0, 0);
      check("pre_rst_go", {31'd0, go_v[12]}, 32'd1);
      #2 resetn = 1'b0;
      #1;
      check("arst_go",    {31'd0, go},   32'd0);
      check("arst_done",  {31'd0, done}, 32'd0);
      check("arst_dout",  {24'd0, data_out}, 32'd0);
      check("arst_ready", {31'd0, ready}, 32'd1);
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      check("post_rst_ready", {31'd0, ready}, 32'd1);
      check("post_rst_res",   {24'd0, result}, 32'd0);
      launch(8'd3, 8'd5, 8'd7, 8'd2);
      run(30, 0, 0);
      nominal_checks(8'd3, 8'd5, 8'd7, 8'd2, 8'd16);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/poly_operand_feeder.md
Name: poly_operand_feeder

Overview:
- Producer for the press/release operand-load protocol used by the polynomial datapath/control pair.
- Takes four operands (A, B, C, X) in one parallel handshake.
- Drives them one at a time on data_out, with go pulses timed like a button press and release.
- Waits for the evaluation to finish, captures the returned result and signals done. This replaces manual SW/KEY entry for automated board tests.

Parameters:
- DATA_W, 8: width of operands and result.
- GO_HIGH_CYCLES, 2: cycles go is held high per operand (min 1).
- GO_LOW_CYCLES, 2: cycles go is held low after each release (min 1).
- RESULT_WAIT, 4: cycles waited after the final release before sampling result_in (min 1).

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- start  in  1  request to send a new operand set; accepted only when ready=1.
- a_in  in  DATA_W  operand A.
- b_in  in  DATA_W  operand B.
- c_in  in  DATA_W  operand C.
- x_in  in  DATA_W  operand X.
- abort  in  1  synchronous cancel of the current transfer.
- result_in  in  DATA_W  result returned by the receiving datapath.
- data_out  out  DATA_W  operand presented to the receiver.
- go  out  1  active-high load strobe to the receiver (press = 1).
- ready  out  1  high in IDLE.
- busy  out  1  high outside IDLE.
- result  out  DATA_W  last captured result.
- done  out  1  one-cycle pulse when result updates.

Behaviour:
- Reset (async, resetn=0):
  - state=IDLE; go=0, data_out=0, result=0, done=0, ready=1, busy=0.
  - Operand shadow registers, index and counter all clear.
  - go must fall immediately on reset assertion, not at the next edge.
- All outputs are registered, except ready/busy, which decode the state.
- States: IDLE, SETUP, HI, LO, WAIT, CAPTURE.
- IDLE:
  - On start=1 and abort=0, latch a_in, b_in, c_in, x_in into shadow registers.
  - Set idx=0 and go to SETUP.
  - start while busy is ignored; shadow registers do not change.
- SETUP (1 cycle): data_out = operand[idx], go=0. Next state HI.
- HI (GO_HIGH_CYCLES cycles): go=1, data_out held. Next state LO.
- LO (GO_LOW_CYCLES cycles):
  - go=0, data_out held.
  - If idx<3: idx+1, then SETUP. If idx=3: WAIT.
- Operand order is fixed: idx 0=A, 1=B, 2=C, 3=X.
- data_out changes only on entry to SETUP, so it is stable on every edge where go rises, is high, or falls.
- WAIT (RESULT_WAIT cycles): go=0, data_out holds X. Next state CAPTURE.
- CAPTURE (1 cycle):
  - result <= result_in; done=1 in this cycle only.
  - Next state IDLE.
  - done and ready are never high together; ready returns the cycle after done.
- Latency with defaults, start sampled at edge 0:
  - SETUP cycles: 1, 6, 11, 16.
  - go high in cycles 2-3, 7-8, 12-13, 17-18.
  - WAIT cycles 21-24; CAPTURE/done in cycle 25; ready in cycle 26.
  - General total: 4*(1+GO_HIGH_CYCLES+GO_LOW_CYCLES)+RESULT_WAIT+1 cycles.
- Counters:
  - One down-counter of width $clog2(max param)+1, reloaded on every state entry.
  - idx is 2 bits; no wrap occurs, since the exit from idx=3 goes to WAIT.
- abort:
  - In any non-IDLE state, takes effect at the next edge: state=IDLE, go=0, data_out=0.
  - result unchanged, no done pulse.
  - If abort and start are both high in IDLE, abort wins and nothing is latched.
  - An abort during HI produces a truncated press. The receiver is then left in a wait-for-release state; the next transfer realigns it only after the receiver is reset. Software must reset both.
- Arithmetic: no arithmetic in this block; result is a verbatim DATA_W copy of result_in.

Test Plan:
- Nominal: connect to a receiver model (A*A+C, 8-bit). A=3, B=5, C=7, X=2, pulse start -> go high exactly cycles 2-3, 7-8, 12-13, 17-18; data_out 3, 5, 7, 2 stable on those edges; done in cycle 25 with result=16.
- Wrap: A=20, C=10, B=X=0 -> result=154 (400+10 mod 256).
- Busy lockout: start again in cycle 5 with A=9 -> ignored; A=3 still sent, result=16, exactly one done.
- Abort: assert abort in cycle 7 (first go high of B) -> go=0 and data_out=0 in cycle 8, ready=1 from cycle 8, no done, result keeps its previous value.
- Async reset: drop resetn mid-cycle 12 -> go, done and data_out are 0 before the next clk edge; after release, ready=1 and a fresh start gives the nominal timing.
- Parameter sweep: GO_HIGH_CYCLES=1, GO_LOW_CYCLES=3, RESULT_WAIT=1 -> each go pulse is 1 cycle wide, 3 low cycles follow, and done comes 2 cycles after the last LO cycle (total 22 cycles).
